// File: rtl/pe_scatter_ctrl_if.sv
// Handshake bundle between a command/word source and pe_scatter_ctrl,
// carrying the command strobe, input word stream, demux write triple and status.
interface pe_scatter_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 6
);
  logic                  start;
  logic [SEL_WIDTH-1:0]  base;
  logic [SEL_WIDTH:0]    len;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] dmux_data;
  logic [SEL_WIDTH-1:0]  dmux_sel;
  logic                  dmux_en;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, base, len, in_valid, in_data,
    input  in_ready, dmux_data, dmux_sel, dmux_en, busy, done, err
  );

  modport slave (
    input  start, base, len, in_valid, in_data,
    output in_ready, dmux_data, dmux_sel, dmux_en, busy, done, err
  );
endinterface

// File: rtl/pe_scatter_ctrl.sv
// Scatters a buffered word stream into len consecutive (wrapping) demux destinations
// from base; 2-edge minimum accept-to-write latency, 1 word/cycle sustained.
module pe_scatter_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 33,
  parameter int SEL_WIDTH  = $clog2(DATA_DEPTH),
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  pe_scatter_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [SEL_WIDTH:0]   DEPTH_W   = (SEL_WIDTH+1)'(DATA_DEPTH);
  localparam logic [SEL_WIDTH-1:0] LAST_SEL  = SEL_WIDTH'(DATA_DEPTH - 1);
  localparam logic [AW:0]          FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, rd_q;
  logic [AW:0]           cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
  logic [SEL_WIDTH:0]    rem_in_q, rem_out_q;
  logic [DATA_WIDTH-1:0] dmux_data_q;
  logic [SEL_WIDTH-1:0]  dmux_sel_q;
  logic                  dmux_en_q, busy_q, done_q, err_q;
  logic                  rdy, push, pop, cmd_bad;

  // Ready depends only on registered state, never on in_valid.
  assign rdy     = (state_q == LOAD) && (cnt_q != FIFO_FULL) && (rem_in_q != '0);
  assign push    = bus.in_valid && rdy;
  assign pop     = (state_q == LOAD) && (cnt_q != '0);
  assign cmd_bad = ({1'b0, bus.base} >= DEPTH_W) || (bus.len > DEPTH_W);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    ptr_d = (ptr_q == LAST_SEL) ? '0 : ptr_q + SEL_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rem_in_q    <= '0;
      rem_out_q   <= '0;
      dmux_data_q <= '0;
      dmux_sel_q  <= '0;
      dmux_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dmux_en_q   <= 1'b0;
      dmux_sel_q  <= '0;
      dmux_data_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;

      if (push) begin
        mem_q[wr_q] <= bus.in_data;
        wr_q        <= wr_q + AW'(1);
        rem_in_q    <= rem_in_q - (SEL_WIDTH+1)'(1);
      end

      if (pop) begin
        dmux_en_q   <= 1'b1;
        dmux_sel_q  <= ptr_q;
        dmux_data_q <= mem_q[rd_q];
        rd_q        <= rd_q + AW'(1);
        ptr_q       <= ptr_d;
        rem_out_q   <= rem_out_q - (SEL_WIDTH+1)'(1);
      end

      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.start) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else if (bus.len == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q   <= LOAD;
              busy_q    <= 1'b1;
              ptr_q     <= bus.base;
              rem_in_q  <= bus.len;
              rem_out_q <= bus.len;
            end
          end
        end
        LOAD: begin
          // Final write and DONE land in the same cycle.
          if (pop && (rem_out_q == (SEL_WIDTH+1)'(1))) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.dmux_data = dmux_data_q;
  assign bus.dmux_sel  = dmux_sel_q;
  assign bus.dmux_en   = dmux_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_pe_scatter_ctrl.sv
// Randomized bench for pe_scatter_ctrl: a queue-based reference model predicts every
// output each cycle; directed commands cover fill, wrap, bubbles, illegal/empty and reset.
module tb_pe_scatter_ctrl;
  localparam int DW = 8;
  localparam int DD = 33;
  localparam int SW = $clog2(DD);
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_scatter_ctrl_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

  pe_scatter_ctrl #(
    .DATA_WIDTH(DW), .DATA_DEPTH(DD), .SEL_WIDTH(SW), .FIFO_DEPTH(FD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  // Reference model: phases 0=idle 1=filling 2=finished, words held in a queue.
  int           m_phase = 0;
  logic [DW-1:0] m_q[$];
  int           m_acc_left = 0, m_wr_left = 0, m_base = 0, m_nwr = 0;
  bit           m_fired = 1'b0;
  int           e_rdy = 0, e_en = 0, e_sel = 0, e_data = 0, e_busy = 0, e_done = 0, e_err = 0;

  always @(posedge clk) begin : model
    bit rdy_pre;
    rdy_pre = (m_phase == 1) && (m_q.size() < FD) && (m_acc_left > 0);
    m_fired = bus.in_valid && rdy_pre && !rst;
    e_en = 0; e_sel = 0; e_data = 0; e_err = 0;
    if (rst) begin
      m_phase = 0; m_q.delete(); m_acc_left = 0; m_wr_left = 0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
          if (int'(bus.base) >= DD || int'(bus.len) > DD) e_err = 1;
          else if (bus.len == 0) m_phase = 2;
          else begin
            m_phase = 1; m_base = int'(bus.base); m_nwr = 0;
            m_acc_left = int'(bus.len); m_wr_left = int'(bus.len);
          end
        end
        1: begin
          if (m_q.size() > 0) begin
            e_data = int'(m_q.pop_front());
            e_en   = 1;
            e_sel  = (m_base + m_nwr) % DD;
            m_nwr++;
            m_wr_left--;
            if (m_wr_left == 0) m_phase = 2;
          end
          if (m_fired) begin
            m_q.push_back(bus.in_data);
            m_acc_left--;
          end
        end
        default: m_phase = 0;
      endcase
    end
    e_done = (m_phase == 2) ? 1 : 0;
    e_busy = (m_phase != 0) ? 1 : 0;
    e_rdy  = ((m_phase == 1) && (m_q.size() < FD) && (m_acc_left > 0)) ? 1 : 0;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk_eq("in_ready",  int'(bus.in_ready),  e_rdy);
      chk_eq("dmux_en",   int'(bus.dmux_en),   e_en);
      chk_eq("dmux_sel",  int'(bus.dmux_sel),  e_sel);
      chk_eq("dmux_data", int'(bus.dmux_data), e_data);
      chk_eq("busy",      int'(bus.busy),      e_busy);
      chk_eq("done",      int'(bus.done),      e_done);
      chk_eq("err",       int'(bus.err),       e_err);
    end
  end

  // Called at a negedge; returns at a negedge. mode: 0 valid held, 1 alternate, 2 random.
  task automatic run_cmd(input int b, input int l, input int mode, input bit seq,
                         input bit mid_start, input int rst_after, input bit quick);
    int acc = 0;
    bit seen_done = 1'b0;
    bit rst_done = 1'b0;
    bus.start    = 1'b1;
    bus.base     = SW'(b);
    bus.len      = (SW+1)'(l);
    bus.in_valid = (mode != 1);
    bus.in_data  = seq ? 8'h11 : 8'($urandom);
    @(negedge clk);
    for (int c = 0; c < l * 4 + 10; c++) begin
      if (m_phase == 2) seen_done = 1'b1;
      if (quick && seen_done && m_phase == 0) return;
      if (m_fired) begin
        acc++;
        bus.in_data = seq ? 8'((acc + 1) * 17) : 8'($urandom);
      end
      rst = 1'b0;
      if (rst_after > 0 && acc == rst_after && !rst_done) begin
        rst = 1'b1;
        rst_done = 1'b1;
      end
      bus.start = mid_start && (c == 2);
      if (bus.start) begin
        bus.base = SW'((b + 7) % DD);
        bus.len  = (SW+1)'(1);
      end else begin
        bus.base = SW'($urandom);
        bus.len  = (SW+1)'($urandom);
      end
      case (mode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = c[0];
        default: bus.in_valid = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.base = '0; bus.len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    @(posedge clk);
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_cmd(0, 4, 0, 1'b1, 1'b0, 0, 1'b0);   // basic fill 0x11..0x44
    run_cmd(31, 4, 0, 1'b0, 1'b0, 0, 1'b0);  // wrap 31,32,0,1
    run_cmd(5, 3, 1, 1'b0, 1'b0, 0, 1'b0);   // bubbles
    run_cmd(33, 1, 0, 1'b0, 1'b0, 0, 1'b0);  // illegal base
    run_cmd(0, 34, 0, 1'b0, 1'b0, 0, 1'b0);  // illegal len
    run_cmd(7, 0, 0, 1'b0, 1'b0, 0, 1'b0);   // empty pass
    run_cmd(12, 6, 0, 1'b0, 1'b1, 0, 1'b0);  // start ignored mid-pass
    run_cmd(20, 6, 0, 1'b0, 1'b0, 2, 1'b0);  // reset after two accepts
    run_cmd(10, 2, 0, 1'b0, 1'b0, 0, 1'b0);
    run_cmd(3, 5, 0, 1'b0, 1'b0, 0, 1'b1);   // back-to-back commands
    run_cmd(30, 3, 2, 1'b0, 1'b0, 0, 1'b1);
    run_cmd(0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
    run_cmd(32, 33, 0, 1'b0, 1'b0, 0, 1'b1); // full-length wrapping pass

    for (int i = 0; i < 30; i++) begin
      int b, l, mode;
      b    = $urandom_range(0, 36);
      l    = ($urandom_range(0, 9) == 0) ? $urandom_range(34, 40) : $urandom_range(0, 33);
      mode = $urandom_range(0, 2);
      run_cmd(b, l, mode, 1'b0, (l >= 4) && ($urandom_range(0, 3) == 0), 0,
              1'(($urandom_range(0, 1))));
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
